// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative MUL/MULHU/DIVU/REMU.
// Latency: simple ops 1 cycle, multiply/divide WIDTH cycles after the accepting edge.
// Backpressure: result held in DONE while out_ready=0; in_ready=out_ready in DONE, 0 while busy.
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t               state;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic                 hi_sel;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   p;

    logic                 accept;
    logic                 is_mul;
    logic                 is_div;
    logic                 last;
    logic [WIDTH-1:0]     simple_res;
    logic [WIDTH:0]       msum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH-1:0]     mul_res;
    logic [WIDTH:0]       dsh;
    logic                 dge;
    logic [WIDTH-1:0]     ddiff;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     div_res;

    function automatic logic [WIDTH-1:0] simple_op(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic [3:0]       o);
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] r;
        sh = y[SHW-1:0];
        case (o)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = $signed(x) >>> sh;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, x < y};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_MUL) || (state == S_DIV);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op[3:1] == 3'b101);
    assign is_div    = (op[3:1] == 3'b110);
    assign last      = (cnt == CW'(WIDTH - 1));

    // p holds {hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        simple_res = simple_op(a, b, op);
        msum       = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? opa : {WIDTH{1'b0}})};
        mul_next   = {msum, p[WIDTH-1:1]};
        mul_res    = hi_sel ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
        dsh        = p[2*WIDTH-1:WIDTH-1];
        dge        = (dsh >= {1'b0, opb});
        ddiff      = dsh[WIDTH-1:0] - opb;
        div_next   = {(dge ? ddiff : dsh[WIDTH-1:0]), p[WIDTH-2:0], dge};
        if (opb == '0) begin
            div_res = hi_sel ? opa : {WIDTH{1'b1}};
        end else begin
            div_res = hi_sel ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            opa         <= '0;
            opb         <= '0;
            hi_sel      <= 1'b0;
            cnt         <= '0;
            p           <= '0;
            result      <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_MUL: begin
                    p   <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result      <= mul_res;
                        zero        <= (mul_res == '0);
                        div_by_zero <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                S_DIV: begin
                    p   <= div_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result      <= div_res;
                        zero        <= (div_res == '0);
                        div_by_zero <= (opb == '0);
                        state       <= S_DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        opa    <= a;
                        opb    <= b;
                        hi_sel <= op[0];
                        cnt    <= '0;
                        if (is_mul) begin
                            p     <= {{WIDTH{1'b0}}, b};
                            state <= S_MUL;
                        end else if (is_div) begin
                            p     <= {{WIDTH{1'b0}}, a};
                            state <= S_DIV;
                        end else begin
                            result      <= simple_res;
                            zero        <= (simple_res == '0);
                            div_by_zero <= 1'b0;
                            state       <= S_DONE;
                        end
                    end else if (state == S_DONE && out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle 64-bit ALU.
- Keeps the single-cycle op set and the zero flag.
- Adds registered results, valid/ready flow control, and iterative multiply/divide/remainder.
- Sits between decode and writeback in the multi-cycle datapath; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range 8..64.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  a, b, op are valid
- in_ready  output  1  block accepts a new operation this cycle
- a  input  WIDTH  operand A (dividend, multiplicand)
- b  input  WIDTH  operand B (divisor, multiplier, shift amount)
- op  input  4  operation select
- out_valid  output  1  result, zero and div_by_zero are valid
- out_ready  input  1  consumer takes the result this cycle
- result  output  WIDTH  registered result
- zero  output  1  high when result == 0, registered with result
- div_by_zero  output  1  high when the completed DIVU/REMU had b == 0
- busy  output  1  high in MUL or DIV state

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (any time, including mid-iteration):
  - state=IDLE; out_valid=0; result=0; zero=0; div_by_zero=0; busy=0.
  - Any in-flight operation is discarded.
- Op encoding (unsigned unless noted):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA: shift by b[SHW-1:0]; upper bits of b ignored.
  - 1000 SLT (signed, result 0/1), 1001 SLTU (result 0/1).
  - 1010 MUL (low WIDTH bits of a*b), 1011 MULHU (high WIDTH bits of a*b).
  - 1100 DIVU, 1101 REMU.
  - 1110, 1111 reserved: result=0, zero=1, single-cycle timing.
- Add/sub wrap modulo 2^WIDTH; no carry or overflow output.
- States:
  - IDLE: in_ready=1. A transfer occurs on an edge with in_valid & in_ready.
    - Single-cycle ops: result, zero captured at that edge; go to DONE (out_valid=1 the next cycle).
    - MUL/MULHU: go to MUL. DIVU/REMU: go to DIV. Operands latched, step counter cleared.
  - MUL: one shift-add step per clock, 2*WIDTH-bit accumulator. After exactly WIDTH steps, load result (low or high half) and go to DONE.
  - DIV: one restoring-division step per clock. After exactly WIDTH steps, load quotient (DIVU) or remainder (REMU) and go to DONE.
    - b==0: still runs WIDTH steps, then forces DIVU result = all ones, REMU result = a, div_by_zero=1.
  - DONE: out_valid=1; result, zero, div_by_zero held stable while out_ready=0.
    - in_ready = out_ready (pass-through accept).
    - out_ready=1 and in_valid=1: the new op is accepted on the same edge; for a single-cycle op out_valid stays 1 with the new result. Throughput is one simple op per cycle.
    - out_ready=1 and in_valid=0: go to IDLE; out_valid falls.
- Latency, measured from the accepting edge k:
  - simple ops: out_valid high after edge k.
  - MUL/DIV: out_valid high after edge k+WIDTH.
- Inputs a, b, op are ignored outside the accepting edge; changes during MUL/DIV have no effect.
- in_valid must not depend on in_ready; out_valid never depends combinationally on out_ready.
- div_by_zero is cleared on every completion that is not a divide by zero.
- busy = (state==MUL || state==DIV); in_ready=0 while busy.

Test Plan:
- Reset, then ADD a=0,b=0 -> out_valid 1 cycle after accept; result=0, zero=1. Then ADD a=1,b=2 -> result=3, zero=0.
- SUB a=0,b=1 -> result=64'hFFFF_FFFF_FFFF_FFFF. SRA a=64'h8000_0000_0000_0000, b=64'h43 (shift 3) -> 64'hF000_0000_0000_0000. SLT a=-1,b=1 -> 1; SLTU same operands -> 0.
- MUL a=64'hFFFF_FFFF_FFFF_FFFF, b=2 -> out_valid exactly 64 cycles after accept, result=64'hFFFF_FFFF_FFFF_FFFE. MULHU same operands -> result=1. busy=1 and in_ready=0 throughout.
- DIVU a=100,b=7 -> result=14; REMU -> 2. DIVU a=5,b=0 -> result all ones, div_by_zero=1. REMU a=5,b=0 -> result=5.
- Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0. Stream 4 ADDs with out_ready=1 -> one result per cycle: 3, 5, 7, 9.
- Assert reset 10 cycles into a DIVU -> out_valid=0, busy=0, in_ready=1 immediately. The next ADD completes normally.
